// File: rtl/div_pcpi_ctrl_if.sv
// Purpose: bundles the PCPI request/response signals and the divider start/done handshake.
// Latency: none, this is wiring only.
// Backpressure: the core is held off by pcpi_wait; div_start is held high until div_done is seen.
// Ports: slave = the controller (drives the PCPI response and the divider request);
//        master = the core/divider side (drives the PCPI request and the divider result).
interface div_pcpi_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             pcpi_valid;
    logic [31:0]      pcpi_insn;
    logic [WIDTH-1:0] pcpi_rs1;
    logic [WIDTH-1:0] pcpi_rs2;
    logic             pcpi_wr;
    logic [WIDTH-1:0] pcpi_rd;
    logic             pcpi_wait;
    logic             pcpi_ready;
    logic             div_start;
    logic             div_unsigned;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic             div_done;

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, div_q, div_r, div_done,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, div_start, div_unsigned, div_a, div_b
    );

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, div_q, div_r, div_done,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, div_start, div_unsigned, div_a, div_b
    );
endinterface

// File: rtl/div_pcpi_ctrl.sv
// Purpose: decodes DIV/DIVU/REM/REMU on PCPI, runs the serial divider and caches the last result.
// Latency: a cache hit gives ready 1 cycle after valid; a miss gives divider latency + 3 cycles.
// Backpressure: pcpi_wait holds the core during a miss; div_start is held until div_done.
// Ports: clk, resetn (async, active low); bus.slave carries the PCPI request/response
//        and the divider start/unsigned/a/b -> q/r/done handshake.
module div_pcpi_ctrl #(
    parameter int WIDTH    = 32,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    div_pcpi_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Latched request and result hold registers.
    logic             sel_rem;
    logic             aborted;
    logic [WIDTH-1:0] q_hold;
    logic [WIDTH-1:0] r_hold;

    // One-entry result cache. Its key is written only when a run completes
    // unaborted, so an abandoned request never disturbs a valid entry.
    logic             cache_valid;
    logic [WIDTH-1:0] key_a;
    logic [WIDTH-1:0] key_b;
    logic             key_u;
    logic [WIDTH-1:0] cache_q;
    logic [WIDTH-1:0] cache_r;

    logic match;
    logic req_u;
    logic req_rem;
    logic hit;
    logic abort_now;
    logic unused_insn_bits;

    assign match = bus.pcpi_valid
                && (bus.pcpi_insn[6:0]   == 7'b0110011)
                && (bus.pcpi_insn[31:25] == 7'b0000001)
                && bus.pcpi_insn[14];
    assign req_u   = bus.pcpi_insn[12];
    assign req_rem = bus.pcpi_insn[13];
    assign hit     = CACHE_EN && cache_valid
                  && (bus.pcpi_rs1 == key_a)
                  && (bus.pcpi_rs2 == key_b)
                  && (req_u == key_u);

    // The core may drop valid on the very cycle done arrives; that still
    // counts as abandoned, so the result must not be cached.
    assign abort_now = aborted || !bus.pcpi_valid;

    // Register and operand fields are not needed for decode.
    assign unused_insn_bits = ^{bus.pcpi_insn[24:15], bus.pcpi_insn[11:7]};

    assign bus.pcpi_wr = bus.pcpi_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (match) state_nxt = hit ? RESPOND : ISSUE;
            ISSUE:   if (bus.div_done) state_nxt = RELEASE;
            // One idle cycle lets the divider see start low and leave DONE.
            RELEASE: state_nxt = aborted ? IDLE : RESPOND;
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered and set on the edge that enters the state they
    // belong to, so ready coincides with RESPOND and wait with ISSUE/RELEASE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.pcpi_rd      <= '0;
            bus.pcpi_wait    <= 1'b0;
            bus.pcpi_ready   <= 1'b0;
            bus.div_start    <= 1'b0;
            bus.div_unsigned <= 1'b0;
            bus.div_a        <= '0;
            bus.div_b        <= '0;
            sel_rem          <= 1'b0;
            aborted          <= 1'b0;
            q_hold           <= '0;
            r_hold           <= '0;
            cache_valid      <= 1'b0;
            key_a            <= '0;
            key_b            <= '0;
            key_u            <= 1'b0;
            cache_q          <= '0;
            cache_r          <= '0;
        end else begin
            bus.pcpi_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (match) begin
                        bus.div_a        <= bus.pcpi_rs1;
                        bus.div_b        <= bus.pcpi_rs2;
                        bus.div_unsigned <= req_u;
                        sel_rem          <= req_rem;
                        if (hit) begin
                            bus.pcpi_ready <= 1'b1;
                            bus.pcpi_rd    <= req_rem ? cache_r : cache_q;
                        end else begin
                            bus.div_start <= 1'b1;
                            bus.pcpi_wait <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!bus.pcpi_valid) aborted <= 1'b1;
                    if (bus.div_done) begin
                        q_hold        <= bus.div_q;
                        r_hold        <= bus.div_r;
                        bus.div_start <= 1'b0;
                        if (!abort_now) begin
                            key_a       <= bus.div_a;
                            key_b       <= bus.div_b;
                            key_u       <= bus.div_unsigned;
                            cache_q     <= bus.div_q;
                            cache_r     <= bus.div_r;
                            cache_valid <= CACHE_EN;
                        end
                    end
                end
                RELEASE: begin
                    bus.pcpi_wait <= 1'b0;
                    aborted       <= 1'b0;
                    if (!aborted) begin
                        bus.pcpi_ready <= 1'b1;
                        bus.pcpi_rd    <= sel_rem ? r_hold : q_hold;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_pcpi_ctrl.sv
// Purpose: directed bench for div_pcpi_ctrl with a behavioural serial divider.
// Latency: divider model raises done DLAT+1 cycles after start rises.
// Backpressure: the divider model holds done until it sees start low.
module tb_div_pcpi_ctrl;

    localparam int WIDTH = 32;
    localparam int DLAT  = 10;
    // Edges from the accepting edge to the ready edge, inclusive, for a miss:
    // start->done is DLAT+1 cycles, then done sample, RELEASE, RESPOND.
    localparam int MISS_LAT = DLAT + 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    div_pcpi_ctrl_if #(.WIDTH(WIDTH)) bus();

    div_pcpi_ctrl #(.WIDTH(WIDTH), .CACHE_EN(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_starts = 0;
    logic prev_start = 1'b0;

    // Divider results are RISC-V semantics, including the special cases.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic u);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'h0) return {32'hFFFFFFFF, a};
        if (u) return {a / b, a % b};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {a, 32'h0};
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        return {sq, sr};
    endfunction

    logic busy;
    int   cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy         <= 1'b0;
            cnt          <= 0;
            bus.div_done <= 1'b0;
            bus.div_q    <= '0;
            bus.div_r    <= '0;
        end else if (!busy) begin
            if (bus.div_start) begin
                busy <= 1'b1;
                cnt  <= DLAT;
            end
        end else if (!bus.div_done) begin
            if (cnt == 1) begin
                bus.div_done <= 1'b1;
                {bus.div_q, bus.div_r} <= ref_div(bus.div_a, bus.div_b, bus.div_unsigned);
            end else begin
                cnt <= cnt - 1;
            end
        end else if (!bus.div_start) begin
            bus.div_done <= 1'b0;
            busy         <= 1'b0;
        end
    end

    always @(posedge clk) begin
        prev_start <= bus.div_start;
        if (bus.div_start && !prev_start) n_starts <= n_starts + 1;
    end

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit exp_miss, input logic [31:0] exp_rd);
        int n, n_done, n_sfall, s0;
        bit got, wait_ok;
        logic [31:0] rd_seen;
        s0 = n_starts; n = 0; n_done = 0; n_sfall = 0; got = 0; wait_ok = 1;
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk(f3);
        bus.pcpi_rs1   = a;
        bus.pcpi_rs2   = b;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) begin
                // Operand changes mid-run must not reach the divider.
                bus.pcpi_rs1 = ~a;
                bus.pcpi_rs2 = ~b;
            end
            if (bus.pcpi_ready) begin
                got = 1;
            end else begin
                if (!bus.pcpi_wait) wait_ok = 0;
                if (bus.div_done && n_done == 0) n_done = n;
                if (!bus.div_start && n_done != 0 && n_sfall == 0) n_sfall = n;
            end
        end
        bus.pcpi_valid = 1'b0;
        rd_seen = bus.pcpi_rd;
        chk({tag, " ready"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(n), exp_miss ? 32'(MISS_LAT) : 32'd1);
        chk({tag, " rd"}, bus.pcpi_rd, exp_rd);
        chk({tag, " wr"}, 32'(bus.pcpi_wr), 32'd1);
        chk({tag, " wait_at_ready"}, 32'(bus.pcpi_wait), 32'd0);
        chk({tag, " div_runs"}, 32'(n_starts - s0), exp_miss ? 32'd1 : 32'd0);
        if (exp_miss) begin
            chk({tag, " wait_held"}, 32'(wait_ok), 32'd1);
            chk({tag, " start_fall"}, 32'(n_sfall - n_done), 32'd1);
        end
        @(posedge clk); #1;
        chk({tag, " ready_one_cycle"}, {30'd0, bus.pcpi_ready, bus.pcpi_wr}, 32'd0);
        chk({tag, " rd_hold"}, bus.pcpi_rd, rd_seen);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bit saw_ready, seen_done, early_drop, mul_bad;

        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = '0;
        bus.pcpi_rs1   = '0;
        bus.pcpi_rs2   = '0;

        // Reset state.
        #1;
        chk("reset ctl", {27'd0, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr,
                          bus.div_start, bus.div_unsigned}, 32'd0);
        chk("reset rd", bus.pcpi_rd, 32'd0);
        chk("reset div_a", bus.div_a, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Main function and cache behaviour.
        req("div_neg7_2",  3'b100, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD);
        req("rem_hit",     3'b110, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF);
        req("remu_miss",   3'b111, 32'hFFFFFFF9, 32'd2, 1'b1, 32'd1);
        req("divu_by0",    3'b101, 32'd100,      32'd0, 1'b1, 32'hFFFFFFFF);
        req("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000);

        // Abandoned request: valid drops five cycles into ISSUE.
        s0 = n_starts; saw_ready = 0; seen_done = 0; early_drop = 0;
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk(3'b100);
        bus.pcpi_rs1   = 32'd50;
        bus.pcpi_rs2   = 32'd7;
        repeat (6) @(posedge clk);
        #1;
        bus.pcpi_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.pcpi_ready) saw_ready = 1;
            if (bus.div_done) seen_done = 1;
            if (!bus.div_start && !seen_done) early_drop = 1;
        end
        chk("abort no_ready", 32'(saw_ready), 32'd0);
        chk("abort start_held", 32'(early_drop), 32'd0);
        chk("abort done_seen", 32'(seen_done), 32'd1);
        chk("abort idle", {30'd0, bus.pcpi_wait, bus.div_start}, 32'd0);
        chk("abort div_runs", 32'(n_starts - s0), 32'd1);
        req("rem_old_key", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0);

        // Non-divide instruction is ignored.
        mul_bad = 0;
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk(3'b000);
        bus.pcpi_rs1   = 32'd3;
        bus.pcpi_rs2   = 32'd4;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.pcpi_wait || bus.pcpi_ready || bus.div_start) mul_bad = 1;
        end
        bus.pcpi_valid = 1'b0;
        chk("mul ignored", 32'(mul_bad), 32'd0);

        // Reset in the middle of ISSUE.
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk(3'b100);
        bus.pcpi_rs1   = 32'd9;
        bus.pcpi_rs2   = 32'd4;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst busy", {30'd0, bus.pcpi_wait, bus.div_start}, 32'd3);
        resetn = 1'b0;
        #1;
        chk("rst ctl", {27'd0, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr,
                        bus.div_start, bus.div_unsigned}, 32'd0);
        chk("rst div_a", bus.div_a, 32'd0);
        chk("rst rd", bus.pcpi_rd, 32'd0);
        @(negedge clk);
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        req("post_rst_miss", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
